// File: rtl/voice_allocator.sv
// Polyphony scheduler: scans one note key per cycle and maps pressed keys onto
// a small pool of voices, stealing the oldest voice when the pool is exhausted.
module voice_allocator #(
    parameter int NUM_KEYS   = 12,
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_KEYS-1:0]     keys,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [4*NUM_VOICES-1:0] voice_note,
    output logic                    note_on,
    output logic                    note_off,
    output logic [1:0]              evt_voice,
    output logic [3:0]              evt_note
);

    localparam int SCAN_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [AGE_W-1:0]  AGE_MAX  = '1;
    localparam logic [SCAN_W-1:0] SCAN_TOP = SCAN_W'(NUM_KEYS - 1);

    typedef enum logic [1:0] {
        KS_IDLE    = 2'd0,
        KS_PLAYING = 2'd1,
        KS_STOLEN  = 2'd2
    } key_state_t;

    logic [SCAN_W-1:0]       r_scan_idx;
    key_state_t              r_key_st    [NUM_KEYS];
    logic [1:0]              r_key_voice [NUM_KEYS];
    logic [NUM_VOICES-1:0]   r_voice_active;
    logic [4*NUM_VOICES-1:0] r_voice_note;
    logic [AGE_W-1:0]        r_age       [NUM_VOICES];
    logic                    r_note_on;
    logic                    r_note_off;
    logic [1:0]              r_evt_voice;
    logic [3:0]              r_evt_note;

    logic [SCAN_W-1:0]       w_scan_idx_next;
    key_state_t              w_key_st_next    [NUM_KEYS];
    logic [1:0]              w_key_voice_next [NUM_KEYS];
    logic [NUM_VOICES-1:0]   w_voice_active_next;
    logic [4*NUM_VOICES-1:0] w_voice_note_next;
    logic [AGE_W-1:0]        w_age_next       [NUM_VOICES];
    logic                    w_note_on_next;
    logic                    w_note_off_next;
    logic [1:0]              w_evt_voice_next;
    logic [3:0]              w_evt_note_next;

    logic                    w_pressed;
    logic                    w_free_found;
    logic [1:0]              w_free_v;
    logic [1:0]              w_old_v;
    logic [AGE_W-1:0]        w_old_age;
    logic [1:0]              w_alloc_v;
    logic [SCAN_W-1:0]       w_owner;

    // Victim selection: lowest free voice, else oldest (strict > keeps lowest on ties).
    always_comb begin
        w_free_found = 1'b0;
        w_free_v     = '0;
        w_old_v      = '0;
        w_old_age    = r_age[0];
        w_owner      = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!w_free_found && !r_voice_active[v]) begin
                w_free_found = 1'b1;
                w_free_v     = 2'(v);
            end
        end
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (r_age[v] > w_old_age) begin
                w_old_age = r_age[v];
                w_old_v   = 2'(v);
            end
        end
        w_alloc_v = w_free_found ? w_free_v : w_old_v;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (r_key_st[k] == KS_PLAYING && r_key_voice[k] == w_alloc_v)
                w_owner = SCAN_W'(k);
        end
    end

    assign w_pressed = keys[r_scan_idx];

    always_comb begin
        w_scan_idx_next     = r_scan_idx;
        w_key_st_next       = r_key_st;
        w_key_voice_next    = r_key_voice;
        w_voice_active_next = r_voice_active;
        w_voice_note_next   = r_voice_note;
        w_age_next          = r_age;
        w_note_on_next      = 1'b0;
        w_note_off_next     = 1'b0;
        w_evt_voice_next    = '0;
        w_evt_note_next     = '0;
        if (en) begin
            w_scan_idx_next = (r_scan_idx == SCAN_TOP) ? '0 : r_scan_idx + 1'b1;
            case (r_key_st[r_scan_idx])
                KS_IDLE: begin
                    if (w_pressed) begin
                        if (!w_free_found) begin
                            w_key_st_next[w_owner] = KS_STOLEN;
                            w_note_off_next        = 1'b1;
                        end
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (2'(v) == w_alloc_v)
                                w_age_next[v] = '0;
                            else if (r_voice_active[v] && r_age[v] != AGE_MAX)
                                w_age_next[v] = r_age[v] + AGE_W'(1);
                        end
                        w_voice_active_next[w_alloc_v]       = 1'b1;
                        w_voice_note_next[4*w_alloc_v +: 4]  = 4'(r_scan_idx);
                        w_key_st_next[r_scan_idx]            = KS_PLAYING;
                        w_key_voice_next[r_scan_idx]         = w_alloc_v;
                        w_note_on_next                       = 1'b1;
                        w_evt_voice_next                     = w_alloc_v;
                        w_evt_note_next                      = 4'(r_scan_idx);
                    end
                end
                KS_PLAYING: begin
                    if (!w_pressed) begin
                        w_voice_active_next[r_key_voice[r_scan_idx]] = 1'b0;
                        w_age_next[r_key_voice[r_scan_idx]]          = '0;
                        w_key_st_next[r_scan_idx]                    = KS_IDLE;
                        w_note_off_next                              = 1'b1;
                        w_evt_voice_next                             = r_key_voice[r_scan_idx];
                        w_evt_note_next                              = 4'(r_scan_idx);
                    end
                end
                KS_STOLEN: begin
                    if (!w_pressed)
                        w_key_st_next[r_scan_idx] = KS_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_idx     <= '0;
            r_voice_active <= '0;
            r_voice_note   <= '0;
            r_note_on      <= 1'b0;
            r_note_off     <= 1'b0;
            r_evt_voice    <= '0;
            r_evt_note     <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                r_key_st[k]    <= KS_IDLE;
                r_key_voice[k] <= '0;
            end
            for (int v = 0; v < NUM_VOICES; v++)
                r_age[v] <= '0;
        end else begin
            r_scan_idx     <= w_scan_idx_next;
            r_key_st       <= w_key_st_next;
            r_key_voice    <= w_key_voice_next;
            r_voice_active <= w_voice_active_next;
            r_voice_note   <= w_voice_note_next;
            r_age          <= w_age_next;
            r_note_on      <= w_note_on_next;
            r_note_off     <= w_note_off_next;
            r_evt_voice    <= w_evt_voice_next;
            r_evt_note     <= w_evt_note_next;
        end
    end

    assign voice_active = r_voice_active;
    assign voice_note   = r_voice_note;
    assign note_on      = r_note_on;
    assign note_off     = r_note_off;
    assign evt_voice    = r_evt_voice;
    assign evt_note     = r_evt_note;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: per-cycle scoreboard against a behavioural model,
// plus a segment table with hand-derived end-of-segment voice maps and event counts.
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [11:0] keys = '0;
    logic [3:0]  voice_active;
    logic [15:0] voice_note;
    logic        note_on;
    logic        note_off;
    logic [1:0]  evt_voice;
    logic [3:0]  evt_note;

    voice_allocator dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .keys         (keys),
        .voice_active (voice_active),
        .voice_note   (voice_note),
        .note_on      (note_on),
        .note_off     (note_off),
        .evt_voice    (evt_voice),
        .evt_note     (evt_note)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        on;
        logic        off;
        logic [1:0]  ev;
        logic [3:0]  en_;
        logic [3:0]  act;
        logic [15:0] note;
    } out_t;

    // rnd: 0 fixed keys, 1 random keys, 2 random keys and random en
    typedef struct {
        logic [11:0] keys;
        logic        en;
        logic        rst;
        int          rnd;
        int          n;
        logic        chk;
        logic [3:0]  exp_act;
        logic [15:0] exp_note;
        int          exp_on;
        int          exp_off;
    } seg_t;

    out_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   seg_on, seg_off;

    // behavioural model state
    int   m_scan;
    int   m_kst [12];   // 0 idle, 1 playing, 2 stolen
    int   m_kv  [12];
    int   m_act [4];
    int   m_note[4];
    int   m_age [4];

    function automatic out_t model_step(logic [11:0] k, logic e, logic r);
        out_t o;
        int   v, j;
        o = '0;
        if (r) begin
            m_scan = 0;
            for (int i = 0; i < 12; i++) begin m_kst[i] = 0; m_kv[i] = 0; end
            for (int i = 0; i < 4; i++) begin m_act[i] = 0; m_note[i] = 0; m_age[i] = 0; end
        end else if (e) begin
            j = m_scan;
            if (m_kst[j] == 0 && k[j]) begin
                v = -1;
                for (int i = 3; i >= 0; i--) if (m_act[i] == 0) v = i;
                if (v < 0) begin
                    v = 0;
                    for (int i = 1; i < 4; i++) if (m_age[i] > m_age[v]) v = i;
                    for (int i = 0; i < 12; i++) if (m_kst[i] == 1 && m_kv[i] == v) m_kst[i] = 2;
                    o.off = 1'b1;
                end
                for (int i = 0; i < 4; i++)
                    if (i != v && m_act[i] == 1 && m_age[i] < 15) m_age[i]++;
                m_age[v] = 0; m_act[v] = 1; m_note[v] = j;
                m_kst[j] = 1; m_kv[j] = v;
                o.on = 1'b1; o.ev = 2'(v); o.en_ = 4'(j);
            end else if (m_kst[j] == 1 && !k[j]) begin
                v = m_kv[j];
                m_act[v] = 0; m_age[v] = 0; m_kst[j] = 0;
                o.off = 1'b1; o.ev = 2'(v); o.en_ = 4'(j);
            end else if (m_kst[j] == 2 && !k[j]) begin
                m_kst[j] = 0;
            end
            m_scan = (m_scan == 11) ? 0 : m_scan + 1;
        end
        for (int i = 0; i < 4; i++) begin
            o.act[i]        = (m_act[i] != 0);
            o.note[4*i +: 4] = 4'(m_note[i]);
        end
        return o;
    endfunction

    task automatic cycle(input logic [11:0] k, input logic e, input logic r);
        out_t x, a;
        @(negedge clk);
        keys = k; en = e; rst = r;
        exp_q.push_back(model_step(k, e, r));
        @(posedge clk);
        #1;
        a = {note_on, note_off, evt_voice, evt_note, voice_active, voice_note};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty got=%h", a);
        end else begin
            x = exp_q.pop_front();
            if (a !== x) begin
                n_err++;
                $display("FAIL cycle t=%0t got on=%b off=%b v=%0d n=%0d act=%b note=%h want on=%b off=%b v=%0d n=%0d act=%b note=%h",
                         $time, a.on, a.off, a.ev, a.en_, a.act, a.note, x.on, x.off, x.ev, x.en_, x.act, x.note);
            end
        end
        if (note_on)  seg_on++;
        if (note_off) seg_off++;
    endtask

    task automatic run_seg(input seg_t s, input string name);
        logic [11:0] k;
        logic        e;
        seg_on = 0; seg_off = 0;
        for (int i = 0; i < s.n; i++) begin
            k = (s.rnd != 0) ? 12'($urandom) : s.keys;
            e = (s.rnd == 2) ? 1'($urandom_range(0, 1)) : s.en;
            cycle(k, e, s.rst);
        end
        if (s.chk) begin
            n_cmp += 3;
            if (voice_active !== s.exp_act || voice_note !== s.exp_note) begin
                n_err++;
                $display("FAIL %s voices got act=%b note=%h want act=%b note=%h", name, voice_active, voice_note, s.exp_act, s.exp_note);
            end
            if (seg_on != s.exp_on) begin
                n_err++;
                $display("FAIL %s note_on_count got=%0d want=%0d", name, seg_on, s.exp_on);
            end
            if (seg_off != s.exp_off) begin
                n_err++;
                $display("FAIL %s note_off_count got=%0d want=%0d", name, seg_off, s.exp_off);
            end
        end
        $display("seg %s cycles=%0d on=%0d off=%0d act=%b note=%h", name, s.n, seg_on, seg_off, voice_active, voice_note);
    endtask

    seg_t tbl [13];
    seg_t s;

    initial begin
        //         keys     en    rst   rnd n   chk   act    note      on off
        tbl[0]  = '{12'h000, 1'b0, 1'b1, 0, 2,  1'b1, 4'h0, 16'h0000, 0, 0};
        tbl[1]  = '{12'h000, 1'b1, 1'b0, 0, 24, 1'b1, 4'h0, 16'h0000, 0, 0};
        tbl[2]  = '{12'h008, 1'b1, 1'b0, 0, 12, 1'b1, 4'h1, 16'h0003, 1, 0};
        tbl[3]  = '{12'h000, 1'b1, 1'b0, 0, 12, 1'b1, 4'h0, 16'h0003, 0, 1};
        tbl[4]  = '{12'h295, 1'b1, 1'b0, 0, 12, 1'b1, 4'hF, 16'h7429, 5, 1};
        tbl[5]  = '{12'h295, 1'b1, 1'b0, 0, 12, 1'b1, 4'hF, 16'h7429, 0, 0};
        tbl[6]  = '{12'h294, 1'b1, 1'b0, 0, 12, 1'b1, 4'hF, 16'h7429, 0, 0};
        tbl[7]  = '{12'h284, 1'b1, 1'b0, 0, 12, 1'b1, 4'hB, 16'h7429, 0, 1};
        tbl[8]  = '{12'hA84, 1'b1, 1'b0, 0, 12, 1'b1, 4'hF, 16'h7B29, 1, 0};
        tbl[9]  = '{12'hA84, 1'b0, 1'b0, 1, 20, 1'b1, 4'hF, 16'h7B29, 0, 0};
        tbl[10] = '{12'hA84, 1'b1, 1'b0, 0, 12, 1'b1, 4'hF, 16'h7B29, 0, 0};
        tbl[11] = '{12'hA84, 1'b1, 1'b1, 0, 1,  1'b1, 4'h0, 16'h0000, 0, 0};
        tbl[12] = '{12'hA84, 1'b1, 1'b0, 0, 12, 1'b1, 4'hF, 16'hB972, 4, 0};

        for (int i = 0; i < 13; i++)
            run_seg(tbl[i], $sformatf("tbl%0d", i));

        // Cycle voice 3 fourteen times so voices 0..2 saturate and tie at max age.
        for (int i = 0; i < 14; i++) begin
            s = '{12'h284, 1'b1, 1'b0, 0, 12, 1'b1, 4'h7, 16'hB972, 0, 1};
            run_seg(s, $sformatf("rel11_%0d", i));
            s = '{12'hA84, 1'b1, 1'b0, 0, 12, 1'b1, 4'hF, 16'hB972, 1, 0};
            run_seg(s, $sformatf("prs11_%0d", i));
        end
        // Saturated tie resolves to voice 0; its owner (key 2) goes silent.
        s = '{12'hA85, 1'b1, 1'b0, 0, 12, 1'b1, 4'hF, 16'hB970, 1, 1};
        run_seg(s, "steal_tie");
        s = '{12'h000, 1'b1, 1'b0, 0, 12, 1'b1, 4'h0, 16'hB970, 0, 4};
        run_seg(s, "release_all");

        s = '{12'h000, 1'b1, 1'b0, 1, 200, 1'b0, 4'h0, 16'h0000, 0, 0};
        run_seg(s, "random");
        s = '{12'h000, 1'b1, 1'b0, 2, 200, 1'b0, 4'h0, 16'h0000, 0, 0};
        run_seg(s, "random_en");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
